// File: rtl/rom_arbiter.sv
// Two-requester arbiter (sound, DMA) in front of a single romController read port.
// Each requester gets a pending flag, an address latch, a data register and a ready pulse.
module rom_arbiter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      s_addr,
  input  logic             s_load,
  output logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic [23:0]      d_addr,
  input  logic             d_load,
  output logic [WIDTH-1:0] d_data,
  output logic             d_ready,
  output logic [23:0]      rom_addr,
  output logic             rom_load,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             rom_ready,
  output logic             busy,
  output logic             grant,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [15:0] TimeoutM1 = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             s_pend_q, s_pend_d, d_pend_q, d_pend_d;
  logic [23:0]      s_lat_q, s_lat_d, d_lat_q, d_lat_d;
  logic [23:0]      rom_addr_q, rom_addr_d;
  logic [WIDTH-1:0] s_data_q, s_data_d, d_data_q, d_data_d;
  logic             grant_q, grant_d, rr_q, rr_d, to_q, to_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             s_busy, d_busy, s_done, d_done, win;

  assign s_busy = (state_q != StIdle) && !grant_q;
  assign d_busy = (state_q != StIdle) && grant_q;
  assign s_done = (state_q == StDone) && !grant_q;
  assign d_done = (state_q == StDone) && grant_q;

  // rr_q names the requester that wins the next contention; it starts at sound.
  assign win = (s_pend_q && d_pend_q) ? ((ROUND_ROBIN != 0) ? rr_q : 1'b0) : d_pend_q;

  always_comb begin
    state_d    = state_q;
    s_pend_d   = s_pend_q;
    d_pend_d   = d_pend_q;
    s_lat_d    = s_lat_q;
    d_lat_d    = d_lat_q;
    rom_addr_d = rom_addr_q;
    s_data_d   = s_data_q;
    d_data_d   = d_data_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    to_d       = to_q;
    cnt_d      = cnt_q;

    // A load in the requester's own ready cycle is the only way to re-arm while in flight.
    if (s_load && !s_pend_q && (!s_busy || s_done)) begin
      s_pend_d = 1'b1;
      s_lat_d  = s_addr;
    end
    if (d_load && !d_pend_q && (!d_busy || d_done)) begin
      d_pend_d = 1'b1;
      d_lat_d  = d_addr;
    end

    unique case (state_q)
      StIdle: begin
        if (s_pend_q || d_pend_q) begin
          state_d    = StIssue;
          grant_d    = win;
          rr_d       = ~win;
          rom_addr_d = win ? d_lat_q : s_lat_q;
          if (win) d_pend_d = 1'b0;
          else     s_pend_d = 1'b0;
        end
      end
      StIssue, StWait: begin
        if (state_q == StIssue) begin
          to_d    = 1'b0;
          cnt_d   = 16'd0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (rom_ready) begin
          state_d = StDone;
          if (grant_q) d_data_d = rom_data;
          else         s_data_d = rom_data;
        end else if (state_q == StWait && cnt_q == TimeoutM1) begin
          state_d = StDone;
          to_d    = 1'b1;
          if (grant_q) d_data_d = '0;
          else         s_data_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      s_pend_q   <= 1'b0;
      d_pend_q   <= 1'b0;
      s_lat_q    <= '0;
      d_lat_q    <= '0;
      rom_addr_q <= '0;
      s_data_q   <= '0;
      d_data_q   <= '0;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_pend_q   <= s_pend_d;
      d_pend_q   <= d_pend_d;
      s_lat_q    <= s_lat_d;
      d_lat_q    <= d_lat_d;
      rom_addr_q <= rom_addr_d;
      s_data_q   <= s_data_d;
      d_data_q   <= d_data_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
    end
  end

  assign s_data      = s_data_q;
  assign d_data      = d_data_q;
  assign s_ready     = s_done;
  assign d_ready     = d_done;
  assign rom_addr    = rom_addr_q;
  assign rom_load    = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign grant       = grant_q;
  assign timeout_err = (state_q == StDone) && to_q;

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter WIDTH, 8, ROM data width; matches the romController WIDTH.
REQ-002 Parameter TIMEOUT, 255, maximum cycles to wait for rom_ready before abandoning a read; legal range 2..65535.
REQ-003 Parameter ROUND_ROBIN, 0, arbitration policy: 0 = fixed priority (sound wins), 1 = alternate on contention.
REQ-004 Port clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port s_addr  in  24  sound requester byte address, sampled with s_load.
REQ-007 Port s_load  in  1  sound read request; each high cycle is one request.
REQ-008 Port s_data  out  WIDTH  sound read data; valid from s_ready until the next sound completion.
REQ-009 Port s_ready  out  1  sound completion; one-cycle pulse.
REQ-010 Port d_addr, d_load, d_data, d_ready; same widths and meanings as the s_* ports, for the DMA requester.
REQ-011 Port rom_addr  out  24  address to romController.
REQ-012 Port rom_load  out  1  read start to romController; one-cycle pulse.
REQ-013 Port rom_data  in  WIDTH  read data from romController.
REQ-014 Port rom_ready  in  1  romController completion pulse.
REQ-015 Port busy  out  1  high in any state other than IDLE.
REQ-016 Port grant  out  1  owner of the current or last transaction: 0 = sound, 1 = DMA.
REQ-017 Port timeout_err  out  1  one-cycle pulse when a read is abandoned.

Function
REQ-018 Each requester SHALL have a pending flag and a 24-bit address latch. A load with the flag clear sets the flag and latches the address on that edge.
REQ-019 A load while that requester's flag is set, or while its transaction is in flight, SHALL be dropped. Exception: a load in the same cycle as that requester's ready pulse SHALL be accepted.
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-021 In IDLE with at least one flag set, the FSM SHALL move to ISSUE on the next edge. On that edge it loads grant and drives rom_addr from the winner's latch.
REQ-022 Arbitration on contention: with ROUND_ROBIN=0, sound SHALL win. With ROUND_ROBIN=1, the requester not granted last SHALL win.
REQ-023 In ISSUE, rom_load SHALL be high for exactly one cycle, and the next edge SHALL enter WAIT. The winner's pending flag clears on entry to ISSUE.
REQ-024 rom_addr SHALL remain stable from ISSUE through DONE.
REQ-025 On the edge that samples rom_ready high in ISSUE or WAIT, the arbiter SHALL capture rom_data into the granted requester's data register and enter DONE.
REQ-026 In DONE, the granted requester's ready SHALL be high for exactly one cycle, then the FSM returns to IDLE. Back-to-back requests therefore cost at least three cycles of overhead.
REQ-027 A 16-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-028 When the wait counter reaches TIMEOUT without rom_ready, the arbiter SHALL load zero into the granted requester's data register and enter DONE. In the DONE cycle, timeout_err pulses together with that requester's ready.
REQ-029 rom_ready in IDLE or DONE, including a late pulse after a timeout, SHALL be ignored.
REQ-030 The non-granted requester's data register and ready SHALL be unaffected by any transaction.
REQ-031 Under ROUND_ROBIN=0, sustained sound traffic MAY starve DMA. This is accepted behaviour.

Reset
REQ-032 While rst is high, the following SHALL be forced immediately, regardless of clk:
- state = IDLE
- pending flags cleared; round-robin pointer = sound
- rom_load, s_ready, d_ready, busy, timeout_err = 0
- grant = 0; rom_addr = 0; s_data = d_data = 0
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no ready pulse. A rom_ready arriving after reset release SHALL be ignored.

Verification
REQ-034 Single read: s_load with s_addr=0x000123; ROM model returns 0xA5 three cycles after rom_load. Required: one rom_load pulse with rom_addr=0x000123, then s_data=0xA5 with a single s_ready pulse; d_ready stays 0.
REQ-035 Contention, ROUND_ROBIN=0: s_load(0x10) and d_load(0x20) in the same cycle. Required: sound served first, DMA second; grant goes 0 then 1; exactly two rom_load pulses.
REQ-036 Contention, ROUND_ROBIN=1: three consecutive cycles of simultaneous s_load/d_load, each re-raised on its own ready. Required: grant sequence 0,1,0,1.
REQ-037 Timeout, TIMEOUT=8: rom_ready never asserted. Required: d_ready and timeout_err pulse together 8 WAIT cycles after entering WAIT, with d_data=0. A later rom_ready pulse is ignored.
REQ-038 Drop and overlap: a second s_load during WAIT is dropped. An s_load in the s_ready cycle is accepted and produces a new rom_load after IDLE.
REQ-039 Reset mid-WAIT: rst pulsed high. Required: all outputs return to their reset values immediately, no ready pulse occurs, and a subsequent rom_ready is ignored.
